// File: rtl/nibble_adder_pkg.sv
// nibble_adder_pkg: shared command/state encodings and the default operand width for the nibble-serial adder.
package nibble_adder_pkg;
    localparam int NIBBLES_DEF = 4;
    typedef enum logic [1:0] {
        CMD_NOP = 2'b00,
        CMD_A   = 2'b01,
        CMD_B   = 2'b10,
        CMD_RUN = 2'b11
    } cmd_t;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADD  = 2'b01,
        ST_DONE = 2'b10
    } state_t;
endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if: 8-bit tile input/output bus of the nibble-serial adder.
interface nibble_serial_adder_ctrl_if;
    logic [7:0] io_in;
    logic [7:0] io_out;
    modport master (output io_in, input io_out);
    modport slave (input io_in, output io_out);
endinterface

// File: rtl/nibble_adder.sv
// nibble_adder: 4-bit ripple-carry adder from and/or/xor full-adder cells, exposing the carry into bit 3.
module nibble_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c3,
    output logic       o_c4
);
    logic [4:0] w_c;
    assign w_c[0] = i_c;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    assign o_c3 = w_c[3];
    assign o_c4 = w_c[4];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: sequences one 4-bit adder over NIBBLES passes to form a 4*NIBBLES-bit add.
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
) (
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);

    logic         w_clk;
    logic         w_rst_n;
    cmd_t         w_cmd;
    logic [3:0]   w_data;
    logic [3:0]   w_s;
    logic         w_c3;
    logic         w_c4;
    logic         w_last;
    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_r;
    logic         r_carry;
    logic         r_ovf;
    logic [CW-1:0] r_cnt;

    assign w_clk   = bus.io_in[0];
    assign w_rst_n = bus.io_in[1];
    assign w_cmd   = cmd_t'(bus.io_in[3:2]);
    assign w_data  = bus.io_in[7:4];
    assign w_last  = r_cnt == CW'(NIBBLES - 1);

    nibble_adder u_add (
        .i_a  (r_a[3:0]),
        .i_b  (r_b[3:0]),
        .i_c  (r_carry),
        .o_s  (w_s),
        .o_c3 (w_c3),
        .o_c4 (w_c4)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = (w_cmd == CMD_RUN) ? ST_ADD : ST_IDLE;
            ST_ADD:  w_state_nxt = w_last ? ST_DONE : ST_ADD;
            ST_DONE: w_state_nxt = (w_cmd == CMD_RUN) ? ST_IDLE : ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operands rotate during ADD so a re-RUN sees them restored.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd == CMD_A) r_a <= {w_data, r_a[W-1:4]};
                    if (w_cmd == CMD_B) r_b <= {w_data, r_b[W-1:4]};
                    if (w_cmd == CMD_RUN) begin
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                    end
                end
                ST_ADD: begin
                    r_r     <= {w_s, r_r[W-1:4]};
                    r_carry <= w_c4;
                    r_a     <= {r_a[3:0], r_a[W-1:4]};
                    r_b     <= {r_b[3:0], r_b[W-1:4]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) r_ovf <= w_c3 ^ w_c4;
                end
                ST_DONE: if (w_cmd == CMD_A) r_r <= {r_r[3:0], r_r[W-1:4]};
                default: ;
            endcase
        end
    end

    assign bus.io_out = {r_ovf, r_state == ST_DONE, r_state == ST_ADD, r_carry, r_r[3:0]};
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed stimulus with an arithmetic reference model checked every cycle.
module tb_nibble_serial_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;
    localparam logic [1:0] NOP = 2'b00, LDA = 2'b01, LDB = 2'b10, RUN = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cmd = NOP;
    logic [3:0] data = 4'h0;
    int checks = 0;
    int errors = 0;

    nibble_serial_adder_ctrl_if bus ();
    assign bus.io_in = {data, cmd, rst_n, clk};

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (.bus(bus));

    always #5 clk = ~clk;

    // Reference: whole-word sum computed at RUN, revealed after N busy cycles.
    int         m_st = 0;
    int         m_k = 0;
    bit         m_ok = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0, m_r = '0;
    logic [W:0]   m_sum = '0;
    logic         m_c = 1'b0, m_v = 1'b0, m_vp = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok = 1'b1;
            m_st = 0;
            m_a = '0;
            m_b = '0;
            m_r = '0;
            m_c = 1'b0;
            m_v = 1'b0;
        end else if (m_st == 0) begin
            if (cmd == LDA) m_a = {data, m_a[W-1:4]};
            if (cmd == LDB) m_b = {data, m_b[W-1:4]};
            if (cmd == RUN) begin
                m_sum = {1'b0, m_a} + {1'b0, m_b};
                m_vp = (m_a[W-1] == m_b[W-1]) && (m_sum[W-1] != m_a[W-1]);
                m_k = N;
                m_st = 1;
            end
        end else if (m_st == 1) begin
            m_k--;
            if (m_k == 0) begin
                m_r = m_sum[W-1:0];
                m_c = m_sum[W];
                m_v = m_vp;
                m_st = 2;
            end
        end else begin
            if (cmd == LDA) m_r = {m_r[3:0], m_r[W-1:4]};
            if (cmd == RUN) m_st = 0;
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp, msk;
        if (m_ok) begin
            exp = {m_v, m_st == 2, m_st == 1, m_c, m_r[3:0]};
            msk = (m_st == 1) ? 8'hE0 : 8'hFF;
            checks++;
            if ((bus.io_out & msk) !== (exp & msk)) begin
                errors++;
                $display("FAIL cycle_model t=%0t: io_out %h, required %h (mask %h)", $time, bus.io_out, exp, msk);
            end
        end
    end

    task automatic step(input logic [1:0] c, input logic [3:0] d);
        cmd = c;
        data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_eq(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < N; i++) step(LDA, a[4*i +: 4]);
        for (int i = 0; i < N; i++) step(LDB, b[4*i +: 4]);
    endtask

    task automatic run_add(input logic [1:0] c_busy);
        step(RUN, 4'h0);
        for (int i = 0; i < N; i++) step(c_busy, 4'hF);
    endtask

    initial begin
        step(NOP, 4'h0);
        step(NOP, 4'h0);
        rst_n = 1'b1;
        expect_eq("reset", bus.io_out, 8'h00);

        load(16'h1234, 16'h0FFF);
        step(RUN, 4'h0);
        expect_eq("busy_first", {6'h0, bus.io_out[6:5]}, 8'h01);
        for (int i = 0; i < N - 1; i++) step(NOP, 4'h0);
        expect_eq("busy_last", {6'h0, bus.io_out[6:5]}, 8'h01);
        step(NOP, 4'h0);
        expect_eq("basic_done", bus.io_out, 8'h43);
        step(LDA, 4'h0);
        expect_eq("basic_n1", {4'h0, bus.io_out[3:0]}, 8'h03);
        step(LDA, 4'h0);
        expect_eq("basic_n2", {4'h0, bus.io_out[3:0]}, 8'h02);
        step(LDA, 4'h0);
        expect_eq("basic_n3", {4'h0, bus.io_out[3:0]}, 8'h02);
        step(LDB, 4'h0);
        step(LDA, 4'h0);
        expect_eq("basic_wrap", bus.io_out, 8'h43);
        step(RUN, 4'h0);
        expect_eq("basic_ack", bus.io_out, 8'h03);

        load(16'hFFFF, 16'h0001);
        run_add(NOP);
        expect_eq("carry_done", bus.io_out, 8'h50);
        step(RUN, 4'h0);

        load(16'h7FFF, 16'h0001);
        run_add(NOP);
        expect_eq("ovf_done", bus.io_out, 8'hC0);
        for (int i = 0; i < N - 1; i++) step(LDA, 4'h0);
        expect_eq("ovf_msn", {4'h0, bus.io_out[3:0]}, 8'h08);
        step(LDA, 4'h0);
        step(RUN, 4'h0);

        run_add(LDA);
        expect_eq("busy_cmds", bus.io_out, 8'hC0);
        step(RUN, 4'h0);
        run_add(NOP);
        expect_eq("rerun", bus.io_out, 8'hC0);
        step(RUN, 4'h0);

        step(RUN, 4'h0);
        step(NOP, 4'h0);
        rst_n = 1'b0;
        step(NOP, 4'h0);
        expect_eq("reset_mid", bus.io_out, 8'h00);
        rst_n = 1'b1;
        load(16'h0123, 16'h4567);
        run_add(NOP);
        expect_eq("post_reset", bus.io_out, 8'h4A);
        step(RUN, 4'h0);

        for (int i = 0; i < N + 2; i++) step(RUN, 4'h0);
        expect_eq("run_held_idle", bus.io_out, 8'h0A);
        step(RUN, 4'h0);
        expect_eq("run_held_busy", {6'h0, bus.io_out[6:5]}, 8'h01);
        for (int i = 0; i < N + 1; i++) step(RUN, 4'h0);
        step(NOP, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
